// File: rtl/mux_n_to_1_stream.sv
// N-to-1 stream selector (explicit select or round-robin) with one registered output stage.
// Latency 1 cycle; ready_out is withheld while resultado is valid and the consumer is not ready_in.
module mux_n_to_1_stream #(
    parameter int WIDTH = 16,
    parameter int N     = 3,
    parameter int SEL_W = 2,
    parameter int MODE  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] data_in,
    input  logic [N-1:0]       valid_in,
    output logic [N-1:0]       ready_out,
    input  logic [SEL_W-1:0]   select,
    output logic [WIDTH-1:0]   resultado,
    output logic               valid_out,
    input  logic               ready_in,
    output logic [SEL_W-1:0]   grant_idx
);

    logic [WIDTH-1:0] resultado_q, resultado_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] last_grant_q, last_grant_d;

    logic             load;
    logic             cand_vld;
    logic [SEL_W-1:0] cand;
    logic [WIDTH-1:0] cand_dat;

    assign load = !valid_q || ready_in;

    always_comb begin
        cand_vld = 1'b0;
        cand     = '0;
        if (MODE == 0) begin
            for (int i = 0; i < N; i++) begin
                if (select == SEL_W'(i) && valid_in[i]) begin
                    cand_vld = 1'b1;
                    cand     = SEL_W'(i);
                end
            end
        end else begin
            // Farthest offset first so the nearest valid channel after last_grant wins.
            for (int k = N; k >= 1; k--) begin
                for (int i = 0; i < N; i++) begin
                    if (((int'(last_grant_q) + k) % N) == i && valid_in[i]) begin
                        cand_vld = 1'b1;
                        cand     = SEL_W'(i);
                    end
                end
            end
        end

        cand_dat = '0;
        for (int i = 0; i < N; i++) begin
            if (cand == SEL_W'(i)) begin
                cand_dat = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ready_out[i] = !rst && load && cand_vld && (cand == SEL_W'(i));
        end
    end

    always_comb begin
        resultado_d  = resultado_q;
        valid_d      = valid_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        if (load) begin
            // With no candidate the data and index hold; only valid drops.
            valid_d = cand_vld;
            if (cand_vld) begin
                resultado_d = cand_dat;
                grant_d     = cand;
                if (MODE != 0) begin
                    last_grant_d = cand;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resultado_q  <= '0;
            valid_q      <= 1'b0;
            grant_q      <= '0;
            last_grant_q <= SEL_W'(N - 1);
        end else begin
            resultado_q  <= resultado_d;
            valid_q      <= valid_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign resultado = resultado_q;
    assign valid_out = valid_q;
    assign grant_idx = grant_q;

endmodule

// File: tb/tb_mux_n_to_1_stream.sv
// Bench for mux_n_to_1_stream: one explicit-select and one round-robin instance side by side.
module tb_mux_n_to_1_stream;

    logic        clk;
    logic        rst;
    logic [47:0] dat;
    logic [1:0]  sel;
    logic [2:0]  vin [2];
    logic [2:0]  ro  [2];
    logic        rin [2];
    logic [15:0] res [2];
    logic        vo  [2];
    logic [1:0]  g   [2];

    int checks = 0;
    int errors = 0;

    localparam logic [47:0] DAT0 = 48'h3333_2222_1111;

    mux_n_to_1_stream #(.WIDTH(16), .N(3), .SEL_W(2), .MODE(0)) u_sel (
        .clk(clk), .rst(rst), .data_in(dat), .valid_in(vin[0]), .ready_out(ro[0]),
        .select(sel), .resultado(res[0]), .valid_out(vo[0]), .ready_in(rin[0]),
        .grant_idx(g[0])
    );

    mux_n_to_1_stream #(.WIDTH(16), .N(3), .SEL_W(2), .MODE(1)) u_rr (
        .clk(clk), .rst(rst), .data_in(dat), .valid_in(vin[1]), .ready_out(ro[1]),
        .select(sel), .resultado(res[1]), .valid_out(vo[1]), .ready_in(rin[1]),
        .grant_idx(g[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int          m;
        logic [1:0]  sel;
        logic [2:0]  vin;
        logic        rin;
        logic [47:0] dat;
        logic [2:0]  ro;
        logic        vo;
        logic [15:0] res;
        logic [1:0]  g;
    } vec_t;

    typedef struct {
        int          m;
        logic [15:0] d;
        logic [1:0]  g;
    } exp_t;

    vec_t tv[$];
    exp_t sb[$];

    always @(posedge rst) sb.delete();

    // Words accepted at a channel must leave the output once each, in order.
    always @(negedge clk) begin
        if (!rst) begin
            for (int m = 0; m < 2; m++) begin
                if (vo[m] && rin[m]) begin
                    int idx;
                    idx = -1;
                    for (int j = sb.size() - 1; j >= 0; j--) begin
                        if (sb[j].m == m) idx = j;
                    end
                    if (idx < 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected_word dut=%0d actual=%0h required=none", m, res[m]);
                    end else begin
                        chk($sformatf("sb_data_dut%0d", m), 48'(res[m]), 48'(sb[idx].d));
                        chk($sformatf("sb_grant_dut%0d", m), 48'(g[m]), 48'(sb[idx].g));
                        sb.delete(idx);
                    end
                end
            end
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < 3; i++) begin
                    if (ro[m][i] && vin[m][i]) begin
                        sb.push_back('{m, dat[i*16 +: 16], 2'(i)});
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sel = 2'd0; dat = DAT0;
        vin[0] = 3'b111; vin[1] = 3'b111; rin[0] = 1'b0; rin[1] = 1'b0;
        #3;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("reset_res%0d", m), 48'(res[m]), 48'h0);
            chk($sformatf("reset_vo%0d", m), 48'(vo[m]), 48'h0);
            chk($sformatf("reset_g%0d", m), 48'(g[m]), 48'h0);
            chk($sformatf("reset_ro%0d", m), 48'(ro[m]), 48'h0);
        end
        #10;
        rst = 1'b0; vin[0] = 3'b000; vin[1] = 3'b000; rin[0] = 1'b1; rin[1] = 1'b1;

        // Explicit select: m sel vin rin dat | ro vo res g
        tv.push_back('{0, 2'd0, 3'b111, 1'b1, DAT0, 3'b001, 1'b1, 16'h1111, 2'd0});
        tv.push_back('{0, 2'd1, 3'b111, 1'b1, DAT0, 3'b010, 1'b1, 16'h2222, 2'd1});
        tv.push_back('{0, 2'd3, 3'b111, 1'b1, DAT0, 3'b000, 1'b0, 16'h2222, 2'd1});
        tv.push_back('{0, 2'd2, 3'b111, 1'b1, DAT0, 3'b100, 1'b1, 16'h3333, 2'd2});
        tv.push_back('{0, 2'd0, 3'b111, 1'b0, 48'hAAAA_AAAA_AAAA, 3'b000, 1'b1, 16'h3333, 2'd2});
        tv.push_back('{0, 2'd1, 3'b111, 1'b0, 48'hBBBB_BBBB_BBBB, 3'b000, 1'b1, 16'h3333, 2'd2});
        tv.push_back('{0, 2'd3, 3'b111, 1'b0, 48'hCCCC_CCCC_CCCC, 3'b000, 1'b1, 16'h3333, 2'd2});
        tv.push_back('{0, 2'd0, 3'b101, 1'b0, 48'hDDDD_DDDD_DDDD, 3'b000, 1'b1, 16'h3333, 2'd2});
        tv.push_back('{0, 2'd1, 3'b111, 1'b1, DAT0, 3'b010, 1'b1, 16'h2222, 2'd1});
        tv.push_back('{0, 2'd2, 3'b011, 1'b1, DAT0, 3'b000, 1'b0, 16'h2222, 2'd1});
        tv.push_back('{0, 2'd0, 3'b000, 1'b1, DAT0, 3'b000, 1'b0, 16'h2222, 2'd1});
        tv.push_back('{0, 2'd0, 3'b001, 1'b0, DAT0, 3'b001, 1'b1, 16'h1111, 2'd0});
        tv.push_back('{0, 2'd2, 3'b111, 1'b0, DAT0, 3'b000, 1'b1, 16'h1111, 2'd0});
        tv.push_back('{0, 2'd2, 3'b111, 1'b1, DAT0, 3'b100, 1'b1, 16'h3333, 2'd2});
        // Round-robin: full rotation, then 101 alternation continuing from the pointer.
        for (int k = 0; k < 6; k++) begin
            tv.push_back('{1, 2'd3, 3'b111, 1'b1, DAT0, 3'(1 << (k % 3)), 1'b1,
                           16'(16'h1111 * ((k % 3) + 1)), 2'(k % 3)});
        end
        for (int k = 0; k < 4; k++) begin
            tv.push_back('{1, 2'd1, 3'b101, 1'b1, DAT0, (k % 2 == 0) ? 3'b001 : 3'b100, 1'b1,
                           (k % 2 == 0) ? 16'h1111 : 16'h3333, (k % 2 == 0) ? 2'd0 : 2'd2});
        end
        // Round-robin under downstream stall: grants 1,2,1,2 across rin 1,0 pairs.
        for (int k = 0; k < 8; k++) begin
            logic [1:0] gg;
            gg = ((k / 2) % 2 == 0) ? 2'd1 : 2'd2;
            tv.push_back('{1, 2'd0, 3'b110, (k % 2 == 0), DAT0,
                           (k % 2 == 0) ? 3'(1 << gg) : 3'b000, 1'b1,
                           16'(16'h1111 * (gg + 1)), gg});
        end
        tv.push_back('{1, 2'd0, 3'b010, 1'b1, DAT0, 3'b010, 1'b1, 16'h2222, 2'd1});
        tv.push_back('{1, 2'd0, 3'b010, 1'b1, DAT0, 3'b010, 1'b1, 16'h2222, 2'd1});
        tv.push_back('{1, 2'd0, 3'b000, 1'b1, DAT0, 3'b000, 1'b0, 16'h2222, 2'd1});
        tv.push_back('{1, 2'd0, 3'b111, 1'b1, DAT0, 3'b100, 1'b1, 16'h3333, 2'd2});

        @(posedge clk); #1;
        for (int k = 0; k < tv.size(); k++) begin
            int m;
            m = tv[k].m;
            vin[0] = 3'b000; vin[1] = 3'b000; rin[0] = 1'b1; rin[1] = 1'b1;
            vin[m] = tv[k].vin; rin[m] = tv[k].rin; sel = tv[k].sel; dat = tv[k].dat;
            #1;
            chk($sformatf("v%0d_ready_out", k), 48'(ro[m]), 48'(tv[k].ro));
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid_out", k), 48'(vo[m]), 48'(tv[k].vo));
            chk($sformatf("v%0d_resultado", k), 48'(res[m]), 48'(tv[k].res));
            chk($sformatf("v%0d_grant_idx", k), 48'(g[m]), 48'(tv[k].g));
        end

        // Asynchronous reset with a held word; round-robin pointer first moved to 0.
        dat = DAT0; sel = 2'd1; vin[0] = 3'b111; rin[0] = 1'b1; vin[1] = 3'b001; rin[1] = 1'b1;
        @(posedge clk); #1;
        chk("pre_reset_res", 48'(res[0]), 48'h2222);
        chk("pre_reset_rr_grant", 48'(g[1]), 48'h0);
        rin[0] = 1'b0; vin[1] = 3'b000;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_res", 48'(res[0]), 48'h0);
        chk("arst_vo", 48'(vo[0]), 48'h0);
        chk("arst_g", 48'(g[0]), 48'h0);
        chk("arst_ro", 48'(ro[0]), 48'h0);
        chk("arst_rr_vo", 48'(vo[1]), 48'h0);
        @(posedge clk); #1;
        chk("arst_held_ro", 48'(ro[0]), 48'h0);
        @(negedge clk);
        rst = 1'b0; vin[0] = 3'b000; rin[0] = 1'b1; vin[1] = 3'b111; rin[1] = 1'b1;
        #1;
        chk("post_reset_rr_ro", 48'(ro[1]), 48'h1);
        @(posedge clk); #1;
        chk("post_reset_rr_grant", 48'(g[1]), 48'h0);
        chk("post_reset_rr_res", 48'(res[1]), 48'h1111);
        vin[1] = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 48'(sb.size()), 48'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_n_to_1_stream.md
Name: mux_n_to_1_stream

Overview:
- Parametrised successor to the datapath's registered 3-to-1 selector.
- Selects one of N WIDTH-bit channels and registers the result on `clk`.
- Adds per-channel valid/ready handshakes, a downstream handshake and a selectable arbitration mode: explicit select, or round-robin among valid channels.
- Sits between producer stages (ALU, memory read, immediate path) and a consumer register stage; one-cycle latency, one transfer per cycle at full throughput.

Parameters:
- WIDTH, 16, data width of each channel and of the output.
- N, 3, number of input channels (N >= 2).
- SEL_W, 2, width of select and grant_idx; must satisfy 2^SEL_W >= N.
- MODE, 0, 0 = explicit select, 1 = round-robin arbitration (select ignored).

Ports:
- clk  input  1  Clock; all state updates on rising edge.
- rst  input  1  Reset: asynchronous, active-high; clears state immediately on assertion.
- data_in  input  N*WIDTH  Flattened channels; channel i occupies bits [i*WIDTH +: WIDTH].
- valid_in  input  N  Channel i offers data.
- ready_out  output  N  Channel i is accepted this cycle; combinational.
- select  input  SEL_W  Channel index in MODE 0.
- resultado  output  WIDTH  Registered selected data.
- valid_out  output  1  resultado holds an untransferred word.
- ready_in  input  1  Downstream accepts resultado.
- grant_idx  output  SEL_W  Registered index of the channel that supplied resultado.

Behaviour:
- Reset values:
  - resultado = 0, valid_out = 0, grant_idx = 0.
  - Round-robin pointer last_grant = N-1, so channel 0 has first priority.
- Handshake rules:
  - load = !valid_out || ready_in.
  - Input transfer occurs on channel i when valid_in[i] && ready_out[i].
  - Output transfer occurs when valid_out && ready_in.
- Candidate selection:
  - MODE 0: cand = select if select < N and valid_in[select]; otherwise no candidate.
  - MODE 1: cand = first i with valid_in[i], scanning from (last_grant+1) mod N upward with wrap to 0. No candidate if valid_in == 0.
- ready_out[i] = load && candidate exists && i == cand. At most one bit of ready_out is set.
- Rising edge with load and a candidate:
  - resultado <= channel cand, valid_out <= 1, grant_idx <= cand.
  - In MODE 1 only: last_grant <= cand.
- Rising edge with load and no candidate:
  - valid_out <= 0.
  - resultado and grant_idx hold their previous values, preserving the legacy hold-on-invalid-select behaviour.
- Rising edge without load (valid_out=1, ready_in=0): all registers hold. resultado must stay stable while stalled.
- Latency and throughput: one cycle from input transfer to valid_out. Back-to-back transfers are possible every cycle while ready_in = 1.
- Out-of-range select (select >= N, MODE 0): no grant, all ready_out = 0. Output drains normally.
- Select change while stalled: has no effect on the held output. The new select applies from the next load.
- MODE 1 with a single valid channel: that channel is granted every cycle, and its index becomes last_grant.
- MODE 1 pointer update: last_grant advances only on an actual grant, never on idle cycles.
- Reset mid-operation: valid_out drops asynchronously and any in-flight word is discarded. No ready_out is asserted while rst = 1.
- Combinational paths:
  - No path from data_in to any output.
  - ready_out depends on ready_in, valid_out, select (MODE 0) and valid_in (MODE 1 arbitration; MODE 0 via valid_in[select]).

Test Plan:
- MODE 0, N=3, WIDTH=16.
  - Stimulus: ready_in=1, all valid_in=1, data = 0x1111/0x2222/0x3333, select 0,1,2 on consecutive cycles.
  - Response: resultado 0x1111, 0x2222, 0x3333 one cycle later each; grant_idx 0,1,2; valid_out continuously 1.
- MODE 0, select = 2'b11.
  - Stimulus: after resultado = 0x2222, drive select = 2'b11.
  - Response: ready_out = 000, valid_out = 0 next cycle, resultado stays 0x2222, grant_idx stays 1.
- MODE 0 stall.
  - Stimulus: ready_in=0 with valid_out=1 holding 0x3333; change select and data for 4 cycles.
  - Response: ready_out = 000, resultado = 0x3333 and grant_idx = 2 unchanged. On ready_in=1 the next selected word loads in the same cycle's edge.
- MODE 1 round-robin.
  - Stimulus: valid_in=111 held, ready_in=1.
  - Response: grants 0,1,2,0,1,2. Then valid_in=101 yields grants alternating 0 and 2, continuing from the pointer.
- MODE 1 with downstream stall.
  - Stimulus: ready_in toggled 1,0,1,0 with valid_in=110.
  - Response: grant sequence 1,2,1,2 with no channel skipped or duplicated; each word transferred exactly once.
- Asynchronous reset.
  - Stimulus: assert rst between clock edges while valid_out=1, resultado=0x2222.
  - Response: resultado=0, valid_out=0, grant_idx=0 without waiting for a clock edge. After release, MODE 1 grants channel 0 first.
